// File: rtl/extio_sweep_ctrl.sv
// rtl/extio_sweep_ctrl.sv - stepped-frequency divider sweep scheduler for the ExtIO test clock
module extio_sweep_ctrl #(
    parameter int CW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cfg_start_div,
    input  logic [CW-1:0] cfg_stop_div,
    input  logic [CW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_loop,
    output logic          busy,
    output logic          done,
    output logic          step_stb,
    output logic [CW-1:0] cur_div,
    output logic          clkout
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic [CW-1:0] cur_q, cur_d, cnt_q, cnt_d;
    logic [DW-1:0] dwell_q, dwell_d, dcnt_q, dcnt_d;
    logic          loop_q, loop_d, up_q, up_d;
    logic          clk_q, clk_d, done_q, done_d, stb_q, stb_d;

    logic [CW-1:0] s_start, s_stop, s_step, next_div;
    logic [DW-1:0] s_dwell;
    logic [CW:0]   sum_up, sum_dn;

    // Zero in any configuration field would stall the divider, so it reads as one.
    assign s_start = (cfg_start_div == '0) ? CW'(1) : cfg_start_div;
    assign s_stop  = (cfg_stop_div  == '0) ? CW'(1) : cfg_stop_div;
    assign s_step  = (cfg_step      == '0) ? CW'(1) : cfg_step;
    assign s_dwell = (cfg_dwell     == '0) ? DW'(1) : cfg_dwell;

    // Step in CW+1 bits so overshoot past the stop value (or below zero) clamps cleanly.
    assign sum_up = {1'b0, cur_q} + {1'b0, step_q};
    assign sum_dn = {1'b0, cur_q} - {1'b0, step_q};

    always_comb begin
        next_div = stop_q;
        if (up_q) begin
            if (sum_up <= {1'b0, stop_q}) next_div = sum_up[CW-1:0];
        end else begin
            if (!sum_dn[CW] && (sum_dn[CW-1:0] >= stop_q)) next_div = sum_dn[CW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        up_d    = up_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        clk_d   = clk_q;
        done_d  = 1'b0;
        stb_d   = 1'b0;
        case (state_q)
            IDLE: begin
                clk_d = 1'b0;
                cnt_d = '0;
                if (start && !abort) begin
                    start_d = s_start;
                    stop_d  = s_stop;
                    step_d  = s_step;
                    dwell_d = s_dwell;
                    loop_d  = cfg_loop;
                    up_d    = (s_stop >= s_start);
                    cur_d   = s_start;
                    dcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    clk_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == cur_q - CW'(1)) begin
                    cnt_d = '0;
                    clk_d = ~clk_q;
                    // Only a falling toggle closes a period, so divider changes never cut a half-period short.
                    if (clk_q) begin
                        if (dcnt_q == dwell_q - DW'(1)) begin
                            dcnt_d = '0;
                            if (cur_q != stop_q) begin
                                cur_d = next_div;
                                stb_d = 1'b1;
                            end else if (loop_q) begin
                                cur_d = start_q;
                                stb_d = 1'b1;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            dcnt_d = dcnt_q + DW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            up_q    <= 1'b0;
            cur_q   <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            clk_q   <= 1'b0;
            done_q  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            up_q    <= up_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            clk_q   <= clk_d;
            done_q  <= done_d;
            stb_q   <= stb_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign step_stb = stb_q;
    assign cur_div  = cur_q;
    assign clkout   = clk_q;

endmodule
